pc_sequencer: RTL and testbench

- Parametrised program-counter unit for each core's fetch stage; successor of the single-width load/increment PC register.
- Adds width/step/reset-vector parameters, signed relative branch, stall, and a hardware return-address stack (RAS) for call/return.
- Drives the instruction-memory address directly from a registered value, so there is no combinational path from the controls to `imaddr`.

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_sequencer_if.sv | 37 +++
 rtl/pc_ras.sv | 42 ++++
 rtl/pc_sequencer.sv | 91 +++++++++
 tb/tb_pc_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program counter.
package pc_pkg;

  localparam int PC_ADDR_W_DEF    = 16;
  localparam int PC_RAS_DEPTH_DEF = 4;

  // One action per cycle, chosen by the priority decode in pc_sequencer.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_STALL,
    OP_CALL,
    OP_RET,
    OP_LOAD,
    OP_BRANCH,
    OP_INC
  } pc_op_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Command/status bundle between the fetch controller and pc_sequencer.
// pc_fault exists only when PC_BOUNDS_CHECK_EN is defined.
interface pc_sequencer_if #(
  parameter int ADDR_W = pc_pkg::PC_ADDR_W_DEF
);
  logic [ADDR_W-1:0] bin;
  logic              wr;
  logic              inc;
  logic              br;
  logic [ADDR_W-1:0] br_off;
  logic              call;
  logic              ret;
  logic              stall;
  logic [ADDR_W-1:0] imaddr;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err;
`ifdef PC_BOUNDS_CHECK_EN
  logic              pc_fault;
`endif

  modport master (
    output bin, wr, inc, br, br_off, call, ret, stall,
    input  imaddr, ras_empty, ras_full, ras_err
`ifdef PC_BOUNDS_CHECK_EN
    , input pc_fault
`endif
  );

  modport slave (
    input  bin, wr, inc, br, br_off, call, ret, stall,
    output imaddr, ras_empty, ras_full, ras_err
`ifdef PC_BOUNDS_CHECK_EN
    , output pc_fault
`endif
  );
endinterface

// File: rtl/pc_ras.sv
// Return-address LIFO: synchronous push/pop, full/empty decoded from sp,
// and a one-cycle error pulse on push-when-full or pop-when-empty.
module pc_ras #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int SP_W  = IDX_W + 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_top,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_err
);

  logic [W-1:0]    r_mem [DEPTH];
  logic [SP_W-1:0] r_sp;
  logic [IDX_W-1:0] w_wr_idx, w_top_idx;

  assign w_wr_idx  = IDX_W'(r_sp);
  assign w_top_idx = IDX_W'(r_sp - 1'b1);
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_sp == '0);
  assign o_full    = (r_sp == SP_W'(DEPTH));
  assign o_err     = (i_push && o_full) || (i_pop && o_empty);

  always_ff @(posedge i_clk) begin
    if (i_rst)                   r_sp <= '0;
    else if (i_push && !o_full)  r_sp <= r_sp + 1'b1;
    else if (i_pop && !o_empty)  r_sp <= r_sp - 1'b1;
  end

  // Entries need no reset: sp alone decides which ones are live.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_push && !o_full) r_mem[w_wr_idx] <= i_din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC: priority decode, PC register, return-address stack, sticky
// flags. PC_BOUNDS_CHECK_EN adds IMEM_WORDS and the sticky pc_fault output.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int ADDR_W    = PC_ADDR_W_DEF,
  parameter int INC_STEP  = 1,
  parameter int RESET_VEC = 0,
  parameter int RAS_DEPTH = PC_RAS_DEPTH_DEF
`ifdef PC_BOUNDS_CHECK_EN
  , parameter int IMEM_WORDS = 1024
`endif
) (
  input  logic           i_clk,
  input  logic           i_rst,
  pc_sequencer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(INC_STEP);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);

  pc_op_e            w_op;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt, w_ras_top;
  logic              w_ras_empty, w_ras_full, w_ras_err;
  logic              r_err;

  always_comb begin
    w_op = OP_HOLD;
    if      (bus.stall) w_op = OP_STALL;
    else if (bus.call)  w_op = OP_CALL;
    else if (bus.ret)   w_op = OP_RET;
    else if (bus.wr)    w_op = OP_LOAD;
    else if (bus.br)    w_op = OP_BRANCH;
    else if (bus.inc)   w_op = OP_INC;
  end

  // Adders wrap modulo 2^ADDR_W; an underflowing ret leaves the PC alone.
  always_comb begin
    w_pc_nxt = r_pc;
    case (w_op)
      OP_CALL:   w_pc_nxt = bus.bin;
      OP_RET:    if (!w_ras_empty) w_pc_nxt = w_ras_top;
      OP_LOAD:   w_pc_nxt = bus.bin;
      OP_BRANCH: w_pc_nxt = r_pc + bus.br_off;
      OP_INC:    w_pc_nxt = r_pc + STEP;
      default:   w_pc_nxt = r_pc;
    endcase
  end

  pc_ras #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_op == OP_CALL),
    .i_pop   (w_op == OP_RET),
    .i_din   (r_pc + STEP),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty),
    .o_full  (w_ras_full),
    .o_err   (w_ras_err)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc  <= RST_PC;
      r_err <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_ras_err) r_err <= 1'b1;
    end
  end

  assign bus.imaddr    = r_pc;
  assign bus.ras_empty = w_ras_empty;
  assign bus.ras_full  = w_ras_full;
  assign bus.ras_err   = r_err;

`ifdef PC_BOUNDS_CHECK_EN
  logic r_fault;
  logic w_oob;

  assign w_oob = ({1'b0, w_pc_nxt} >= (ADDR_W+1)'(IMEM_WORDS));

  always_ff @(posedge i_clk) begin
    if (i_rst)                                             r_fault <= 1'b0;
    else if (w_op != OP_HOLD && w_op != OP_STALL && w_oob) r_fault <= 1'b1;
  end

  assign bus.pc_fault = r_fault;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario bench for pc_sequencer: expected state is queued as each command is
// driven and compared against the sampled outputs at the end of each scenario.
module tb_pc_sequencer;

  typedef struct packed {
    logic [15:0] pc;
    logic        emp;
    logic        ful;
    logic        err;
  } st_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  st_t  q_exp[$];
  st_t  q_obs[$];

  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(16)) bus ();

  pc_sequencer #(.ADDR_W(16), .INC_STEP(1), .RESET_VEC(0), .RAS_DEPTH(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic idle();
    rst = 0; bus.wr = 0; bus.inc = 0; bus.br = 0; bus.call = 0;
    bus.ret = 0; bus.stall = 0; bus.bin = '0; bus.br_off = '0;
  endtask

  // Apply the currently driven command for one edge and record expected/observed.
  task automatic tick(input logic [15:0] pc, input logic emp, ful, err);
    q_exp.push_back({pc, emp, ful, err});
    @(posedge clk);
    #1;
    q_obs.push_back({bus.imaddr, bus.ras_empty, bus.ras_full, bus.ras_err});
    idle();
  endtask

  task automatic test_reset();
    st_t e, o;
    rst = 1; bus.call = 1; bus.inc = 1; bus.bin = 16'h1234; tick(16'h0000, 1, 0, 0);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset: got pc=%h e/f/err=%b%b%b want pc=%h e/f/err=%b%b%b",
                 o.pc, o.emp, o.ful, o.err, e.pc, e.emp, e.ful, e.err);
      end
    end
  endtask

  task automatic test_inc_and_priority();
    st_t e, o;
    int  n = 0;
    for (int i = 1; i <= 3; i++) begin
      bus.inc = 1; tick(16'(i), 1, 0, 0);
    end
    bus.wr = 1; bus.inc = 1; bus.bin = 16'h0100; tick(16'h0100, 1, 0, 0);
    bus.br = 1; bus.inc = 1; bus.br_off = 16'h0008; tick(16'h0108, 1, 0, 0);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); checks++; n++;
      if (o !== e) begin
        failures++;
        $display("FAIL inc_prio#%0d: got pc=%h e/f/err=%b%b%b want pc=%h e/f/err=%b%b%b",
                 n, o.pc, o.emp, o.ful, o.err, e.pc, e.emp, e.ful, e.err);
      end
    end
  endtask

  task automatic test_wrap();
    st_t e, o;
    int  n = 0;
    bus.wr = 1; bus.bin = 16'hFFFE; tick(16'hFFFE, 1, 0, 0);
    bus.inc = 1; tick(16'hFFFF, 1, 0, 0);
    bus.inc = 1; tick(16'h0000, 1, 0, 0);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); checks++; n++;
      if (o !== e) begin
        failures++;
        $display("FAIL wrap#%0d: got pc=%h e/f/err=%b%b%b want pc=%h e/f/err=%b%b%b",
                 n, o.pc, o.emp, o.ful, o.err, e.pc, e.emp, e.ful, e.err);
      end
    end
  endtask

  task automatic test_branch_stall();
    st_t e, o;
    int  n = 0;
    bus.wr = 1; bus.bin = 16'h0020; tick(16'h0020, 1, 0, 0);
    bus.br = 1; bus.br_off = 16'h0005; tick(16'h0025, 1, 0, 0);
    bus.br = 1; bus.br_off = 16'hFFFB; tick(16'h0020, 1, 0, 0);
    bus.br = 1; bus.br_off = 16'hFFF0; tick(16'h0010, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      bus.stall = 1; bus.br = 1; bus.br_off = 16'h0004; tick(16'h0010, 1, 0, 0);
    end
    // A stalled call must neither jump nor push.
    bus.stall = 1; bus.call = 1; bus.bin = 16'h0777; tick(16'h0010, 1, 0, 0);
    bus.stall = 1; bus.ret = 1; tick(16'h0010, 1, 0, 0);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); checks++; n++;
      if (o !== e) begin
        failures++;
        $display("FAIL branch_stall#%0d: got pc=%h e/f/err=%b%b%b want pc=%h e/f/err=%b%b%b",
                 n, o.pc, o.emp, o.ful, o.err, e.pc, e.emp, e.ful, e.err);
      end
    end
  endtask

  task automatic test_nested_calls();
    st_t e, o;
    int  n = 0;
    bus.call = 1; bus.ret = 1; bus.wr = 1; bus.bin = 16'h0100; tick(16'h0100, 0, 0, 0);
    bus.call = 1; bus.bin = 16'h0200; tick(16'h0200, 0, 0, 0);
    bus.call = 1; bus.bin = 16'h0300; tick(16'h0300, 0, 0, 0);
    bus.ret = 1; bus.wr = 1; bus.bin = 16'h0BAD; tick(16'h0201, 0, 0, 0);
    bus.ret = 1; tick(16'h0101, 0, 0, 0);
    bus.ret = 1; tick(16'h0011, 1, 0, 0);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); checks++; n++;
      if (o !== e) begin
        failures++;
        $display("FAIL nested#%0d: got pc=%h e/f/err=%b%b%b want pc=%h e/f/err=%b%b%b",
                 n, o.pc, o.emp, o.ful, o.err, e.pc, e.emp, e.ful, e.err);
      end
    end
  endtask

  task automatic test_overflow();
    st_t e, o;
    int  n = 0;
    bus.call = 1; bus.bin = 16'h1000; tick(16'h1000, 0, 0, 0);
    bus.call = 1; bus.bin = 16'h2000; tick(16'h2000, 0, 0, 0);
    bus.call = 1; bus.bin = 16'h3000; tick(16'h3000, 0, 0, 0);
    bus.call = 1; bus.bin = 16'h4000; tick(16'h4000, 0, 1, 0);
    bus.call = 1; bus.bin = 16'h5000; tick(16'h5000, 0, 1, 1);
    bus.ret = 1; tick(16'h3001, 0, 0, 1);
    bus.inc = 1; tick(16'h3002, 0, 0, 1);
    rst = 1; bus.call = 1; bus.bin = 16'h6000; tick(16'h0000, 1, 0, 0);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); checks++; n++;
      if (o !== e) begin
        failures++;
        $display("FAIL overflow#%0d: got pc=%h e/f/err=%b%b%b want pc=%h e/f/err=%b%b%b",
                 n, o.pc, o.emp, o.ful, o.err, e.pc, e.emp, e.ful, e.err);
      end
    end
  endtask

  task automatic test_underflow();
    st_t e, o;
    int  n = 0;
    bus.wr = 1; bus.bin = 16'h0040; tick(16'h0040, 1, 0, 0);
    bus.ret = 1; bus.inc = 1; tick(16'h0040, 1, 0, 1);
    bus.inc = 1; tick(16'h0041, 1, 0, 1);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); checks++; n++;
      if (o !== e) begin
        failures++;
        $display("FAIL underflow#%0d: got pc=%h e/f/err=%b%b%b want pc=%h e/f/err=%b%b%b",
                 n, o.pc, o.emp, o.ful, o.err, e.pc, e.emp, e.ful, e.err);
      end
    end
`ifdef PC_BOUNDS_CHECK_EN
    checks++;
    if (bus.pc_fault !== 1'b0) begin
      failures++;
      $display("FAIL bounds_clear: got pc_fault=%b want 0", bus.pc_fault);
    end
    bus.wr = 1; bus.bin = 16'h0400; tick(16'h0400, 1, 0, 1);
    e = q_exp.pop_front(); o = q_obs.pop_front(); checks++;
    if (o !== e || bus.pc_fault !== 1'b1) begin
      failures++;
      $display("FAIL bounds_set: got pc=%h pc_fault=%b want pc=%h pc_fault=1",
               o.pc, bus.pc_fault, e.pc);
    end
`endif
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_inc_and_priority();
    test_wrap();
    test_branch_stall();
    test_nested_calls();
    test_overflow();
    test_underflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
